// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Bundles the three channels around the sequencer:
//     request  : req_valid/req_ready handshake, req_op, req_wide, req_usecf, req_a, req_b
//     unit     : alu_a, alu_b, alu_sel (one-hot), alu_cin out; alu_out, alu_zout, alu_cout back
//     response : rsp_valid/rsp_ready handshake, rsp_data, rsp_z, rsp_c, rsp_err
//   slave  : the sequencer side
//   master : the environment side (request source, arithmetic unit, response sink)
interface alu_sequencer_if #(
    parameter int NUM_OPS = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_op;
    logic               req_wide;
    logic               req_usecf;
    logic [31:0]        req_a;
    logic [31:0]        req_b;

    logic [15:0]        alu_a;
    logic [15:0]        alu_b;
    logic [NUM_OPS-1:0] alu_sel;
    logic               alu_cin;
    logic [15:0]        alu_out;
    logic               alu_zout;
    logic               alu_cout;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_z;
    logic               rsp_c;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_op, req_wide, req_usecf, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_sel, alu_cin,
        input  alu_out, alu_zout, alu_cout,
        output rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_wide, req_usecf, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_sel, alu_cin,
        output alu_out, alu_zout, alu_cout,
        input  rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issue-side controller for the 16-bit one-hot-select arithmetic unit.
//   Takes one request at a time, drives one (narrow) or two chained (wide)
//   passes through the unit, and returns result + flags on the response
//   channel. Holds the architectural carry (cf) and zero (zf) flags.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_sequencer_if.slave (request, unit and response channels)
//   cf, zf     : architectural carry / zero flags
module alu_sequencer #(
    parameter int NUM_OPS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic             cf,
    output logic             zf
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t       state;
    logic         wideQ;
    logic         addSubQ;
    logic [15:0]  aHiQ;
    logic [15:0]  bHiQ;
    logic [15:0]  resLo;
    logic         zLo;

    logic               isAddSub;
    logic               illegal;
    logic [NUM_OPS-1:0] selOf;

    assign isAddSub = (bus.req_op == 4'd6) || (bus.req_op == 4'd7);

    // Shifts, mul8 and cmp have no meaningful carry chain, so no wide form.
    assign illegal = (int'(bus.req_op) >= NUM_OPS) ||
                     (bus.req_wide && (bus.req_op == 4'd4 || bus.req_op == 4'd5 ||
                                       bus.req_op == 4'd8 || bus.req_op == 4'd9));

    // Opcode 0 maps to the top select bit, opcode NUM_OPS-1 to bit 0.
    always_comb begin
        selOf = '0;
        for (int i = 0; i < NUM_OPS; i++)
            selOf[i] = (int'(bus.req_op) == NUM_OPS - 1 - i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wideQ         <= 1'b0;
            addSubQ       <= 1'b0;
            aHiQ          <= '0;
            bHiQ          <= '0;
            resLo         <= '0;
            zLo           <= 1'b0;
            cf            <= 1'b0;
            zf            <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.alu_cin   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_z     <= 1'b0;
            bus.rsp_c     <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.req_ready) begin
                        // first cycle out of reset
                        bus.req_ready <= 1'b1;
                    end else if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        wideQ         <= bus.req_wide;
                        addSubQ       <= isAddSub;
                        aHiQ          <= bus.req_a[31:16];
                        bHiQ          <= bus.req_b[31:16];
                        if (illegal) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= '0;
                            bus.rsp_z     <= 1'b0;
                            bus.rsp_c     <= 1'b0;
                        end else begin
                            state         <= LO;
                            bus.rsp_err   <= 1'b0;
                            bus.alu_a     <= bus.req_a[15:0];
                            bus.alu_b     <= bus.req_b[15:0];
                            bus.alu_sel   <= selOf;
                            // cf is stable here: nothing else is in flight
                            bus.alu_cin   <= isAddSub & bus.req_usecf & cf;
                        end
                    end
                end
                LO: begin
                    if (wideQ) begin
                        state       <= HI;
                        resLo       <= bus.alu_out;
                        zLo         <= bus.alu_zout;
                        bus.alu_a   <= aHiQ;
                        bus.alu_b   <= bHiQ;
                        // chain low-half carry/borrow into the high pass
                        bus.alu_cin <= addSubQ & bus.alu_cout;
                    end else begin
                        state         <= RESP;
                        bus.alu_sel   <= '0;
                        bus.alu_cin   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= {16'h0000, bus.alu_out};
                        bus.rsp_z     <= bus.alu_zout;
                        bus.rsp_c     <= bus.alu_cout;
                        cf            <= bus.alu_cout;
                        zf            <= bus.alu_zout;
                    end
                end
                HI: begin
                    state         <= RESP;
                    bus.alu_sel   <= '0;
                    bus.alu_cin   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= {bus.alu_out, resLo};
                    bus.rsp_z     <= zLo & bus.alu_zout;
                    bus.rsp_c     <= bus.alu_cout;
                    cf            <= bus.alu_cout;
                    zf            <= zLo & bus.alu_zout;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        // ready comes back the cycle after the handshake
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Bench for alu_sequencer: a behavioural 16-bit arithmetic unit answers
//   the sequencer's selects, a fixed vector table covers the documented
//   cases, random requests are checked against a 32-bit arithmetic model,
//   and hand sequences cover back-pressure and reset in the middle of a
//   wide operation.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cf, zf;
    int   nVec = 0;
    int   nMis = 0;
    logic mCf, mZf;

    always #5 clk = ~clk;

    alu_sequencer_if #(.NUM_OPS(10)) bus ();

    alu_sequencer #(.NUM_OPS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cf    (cf),
        .zf    (zf)
    );

    // Behavioural arithmetic unit (one 16-bit slice).
    logic [16:0] uT;
    always_comb begin
        uT           = '0;
        bus.alu_out  = '0;
        bus.alu_cout = 1'b0;
        if (bus.alu_sel[9]) bus.alu_out = bus.alu_b;
        else if (bus.alu_sel[8]) bus.alu_out = bus.alu_a & bus.alu_b;
        else if (bus.alu_sel[7]) bus.alu_out = bus.alu_a | bus.alu_b;
        else if (bus.alu_sel[6]) bus.alu_out = ~bus.alu_b;
        else if (bus.alu_sel[5]) begin
            bus.alu_out  = {bus.alu_b[14:0], 1'b0};
            bus.alu_cout = bus.alu_b[15];
        end else if (bus.alu_sel[4]) begin
            bus.alu_out  = {1'b0, bus.alu_b[15:1]};
            bus.alu_cout = bus.alu_b[0];
        end else if (bus.alu_sel[3]) begin
            uT           = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_cin};
            bus.alu_out  = uT[15:0];
            bus.alu_cout = uT[16];
        end else if (bus.alu_sel[2]) begin
            uT           = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {16'h0, bus.alu_cin};
            bus.alu_out  = uT[15:0];
            bus.alu_cout = uT[16];
        end else if (bus.alu_sel[1]) bus.alu_out = bus.alu_a[7:0] * bus.alu_b[7:0];
        else if (bus.alu_sel[0]) bus.alu_cout = bus.alu_a > bus.alu_b;
        bus.alu_zout = bus.alu_sel[0] ? (bus.alu_a == bus.alu_b) : (bus.alu_out == 16'h0);
    end

    // Reference: whole-width arithmetic on the full operands.
    function automatic void model(input logic [3:0] op, input logic wide, input logic usecf,
                                  input logic [31:0] a, input logic [31:0] b, input logic cfIn,
                                  output logic [31:0] d, output logic z, output logic c,
                                  output logic err);
        longint unsigned av, bv, r, m, cin;
        int w;
        err = (op >= 4'd10) || (wide && (op == 4 || op == 5 || op == 8 || op == 9));
        d = '0; z = 1'b0; c = 1'b0;
        if (err) return;
        w   = wide ? 32 : 16;
        m   = (64'd1 << w) - 1;
        av  = a & m;
        bv  = b & m;
        cin = ((op == 6 || op == 7) && usecf && cfIn) ? 1 : 0;
        r   = 0;
        case (op)
            0: r = bv;
            1: r = av & bv;
            2: r = av | bv;
            3: r = ~bv & m;
            4: begin r = (bv << 1) & m; c = ((bv >> 15) & 1) != 0; end
            5: begin r = bv >> 1; c = (bv & 1) != 0; end
            6: begin r = av + bv + cin; c = ((r >> w) & 1) != 0; r = r & m; end
            7: begin c = av < bv + cin; r = (av - bv - cin) & m; end
            8: r = (av & 255) * (bv & 255);
            default: begin r = 0; c = av > bv; end
        endcase
        z = (op == 9) ? (av == bv) : (r == 0);
        d = r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request, watch the unit passes, collect the response.
    task automatic runOp(input logic [3:0] op, input logic wide, input logic usecf,
                         input logic [31:0] a, input logic [31:0] b, input logic illegal,
                         input int hold,
                         output logic [31:0] d, output logic z, output logic c, output logic err,
                         output int lat, output logic selBad, output logic [1:0] cinTr,
                         output logic protoBad);
        int n;
        int passes;
        logic [9:0] expSel;
        logic [9:0] one;
        one = 10'd1;
        expSel = illegal ? 10'd0 : (one << (9 - int'(op)));
        d = '0; z = 1'b0; c = 1'b0; err = 1'b0; lat = 0;
        selBad = 1'b0; cinTr = 2'b00; protoBad = 1'b0; passes = 0;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            chk("req_ready wait timeout", 64'd0, 64'd1);
            return;
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_wide = wide;
        bus.req_usecf = usecf; bus.req_a = a; bus.req_b = b;
        @(posedge clk);
        do begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.alu_sel != 10'd0) begin
                if (bus.alu_sel != expSel) selBad = 1'b1;
                if (passes < 2) cinTr[passes] = bus.alu_cin;
                passes++;
            end
        end while (!bus.rsp_valid && lat < 10);
        if (!bus.rsp_valid) begin
            chk("rsp_valid wait timeout", 64'd0, 64'd1);
            return;
        end
        d = bus.rsp_data; z = bus.rsp_z; c = bus.rsp_c; err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_data !== d || bus.rsp_z !== z ||
                bus.rsp_c !== c || bus.rsp_err !== err || bus.alu_sel != 10'd0)
                protoBad = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) protoBad = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        wide;
        logic        usecf;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        c;
        logic        err;
        int          lat;
        logic        cfE;
        logic        zfE;
        logic [1:0]  cin;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] d, eD;
        logic z, c, err, eZ, eC, eErr, selBad, protoBad, bad;
        logic [1:0] cinTr;
        int lat;

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_wide = 1'b0; bus.req_usecf = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;

        //             op    wide  usecf a             b             data          z     c     err   lat cf    zf    cin{hi,lo}
        tbl[0]  = '{4'd6,  1'b0, 1'b0, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{4'd6,  1'b1, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 2'b10};
        tbl[2]  = '{4'd6,  1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 2'b00};
        tbl[3]  = '{4'd6,  1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2'b01};
        tbl[4]  = '{4'd9,  1'b0, 1'b0, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 2'b00};
        tbl[5]  = '{4'd9,  1'b0, 1'b0, 32'h00000009, 32'h00000002, 32'h00000000, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2'b00};
        tbl[6]  = '{4'd12, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 2'b00};
        tbl[7]  = '{4'd4,  1'b1, 1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 2'b00};
        tbl[8]  = '{4'd7,  1'b0, 1'b0, 32'h00000003, 32'h00000005, 32'h0000FFFE, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2'b00};
        tbl[9]  = '{4'd7,  1'b1, 1'b0, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 2'b10};
        tbl[10] = '{4'd8,  1'b0, 1'b0, 32'h000012FF, 32'h00003402, 32'h000001FE, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2'b00};
        tbl[11] = '{4'd1,  1'b1, 1'b0, 32'hAAAA5555, 32'hFFFF0F0F, 32'hAAAA0505, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 2'b00};
        tbl[12] = '{4'd3,  1'b0, 1'b0, 32'h00000000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 2'b00};
        tbl[13] = '{4'd5,  1'b0, 1'b0, 32'h00000000, 32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2'b00};

        // Reset state
        #1;
        chk("reset ctrl outputs", 64'({bus.req_ready, bus.alu_sel, bus.alu_cin, bus.rsp_valid,
                                       bus.rsp_z, bus.rsp_c, bus.rsp_err, cf, zf}), 64'd0);
        chk("reset data outputs", {bus.alu_a, bus.alu_b, bus.rsp_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready after reset", 64'(bus.req_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            runOp(tbl[i].op, tbl[i].wide, tbl[i].usecf, tbl[i].a, tbl[i].b, tbl[i].err, 0,
                  d, z, c, err, lat, selBad, cinTr, protoBad);
            chk($sformatf("tbl%0d rsp_data", i), 64'(d), 64'(tbl[i].d));
            chk($sformatf("tbl%0d rsp_z", i), 64'(z), 64'(tbl[i].z));
            chk($sformatf("tbl%0d rsp_c", i), 64'(c), 64'(tbl[i].c));
            chk($sformatf("tbl%0d rsp_err", i), 64'(err), 64'(tbl[i].err));
            chk($sformatf("tbl%0d latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("tbl%0d cf", i), 64'(cf), 64'(tbl[i].cfE));
            chk($sformatf("tbl%0d zf", i), 64'(zf), 64'(tbl[i].zfE));
            chk($sformatf("tbl%0d alu_sel", i), 64'(selBad), 64'd0);
            chk($sformatf("tbl%0d alu_cin", i), 64'(cinTr), 64'(tbl[i].cin));
        end
        mCf = tbl[13].cfE;
        mZf = tbl[13].zfE;

        // Random requests against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic wide, usecf;
            logic [31:0] a, b;
            int hold;
            op    = 4'($urandom_range(0, 11));
            wide  = 1'($urandom_range(0, 1));
            usecf = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
            if (i % 5 == 0) b = a;
            hold  = $urandom_range(0, 2);
            model(op, wide, usecf, a, b, mCf, eD, eZ, eC, eErr);
            runOp(op, wide, usecf, a, b, eErr, hold, d, z, c, err, lat, selBad, cinTr, protoBad);
            if (!eErr) begin mCf = eC; mZf = eZ; end
            chk($sformatf("rnd%0d op%0d w%0d rsp_data", i, op, wide), 64'(d), 64'(eD));
            chk($sformatf("rnd%0d rsp_z", i), 64'(z), 64'(eZ));
            chk($sformatf("rnd%0d rsp_c", i), 64'(c), 64'(eC));
            chk($sformatf("rnd%0d rsp_err", i), 64'(err), 64'(eErr));
            chk($sformatf("rnd%0d latency", i), 64'(lat), 64'(eErr ? 1 : (wide ? 3 : 2)));
            chk($sformatf("rnd%0d cf", i), 64'(cf), 64'(mCf));
            chk($sformatf("rnd%0d zf", i), 64'(zf), 64'(mZf));
            chk($sformatf("rnd%0d alu_sel", i), 64'(selBad), 64'd0);
            chk($sformatf("rnd%0d handshake", i), 64'(protoBad), 64'd0);
        end

        // Back-pressure: hold rsp_ready low for 5 cycles
        model(4'd2, 1'b1, 1'b0, 32'h12340000, 32'h00005678, mCf, eD, eZ, eC, eErr);
        runOp(4'd2, 1'b1, 1'b0, 32'h12340000, 32'h00005678, 1'b0, 5,
              d, z, c, err, lat, selBad, cinTr, protoBad);
        mCf = eC; mZf = eZ;
        chk("backpressure rsp_data", 64'(d), 64'(eD));
        chk("backpressure stable", 64'(protoBad), 64'd0);

        // Reset in the middle of the high pass of a wide add
        bad = 1'b0;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
        chk("midreset req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_op = 4'd6; bus.req_wide = 1'b1; bus.req_usecf = 1'b0;
        bus.req_a = 32'h1234FFFF; bus.req_b = 32'h00010001;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midreset HI alu_a", 64'(bus.alu_a), 64'h1234);
        chk("midreset HI alu_cin", 64'(bus.alu_cin), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset ctrl outputs", 64'({bus.req_ready, bus.alu_sel, bus.alu_cin, bus.rsp_valid,
                                          bus.rsp_z, bus.rsp_c, bus.rsp_err, cf, zf}), 64'd0);
        chk("midreset data outputs", {bus.alu_a, bus.alu_b, bus.rsp_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.alu_sel != 10'd0) bad = 1'b1;
        end
        chk("no response after reset", 64'(bad), 64'd0);
        mCf = 1'b0; mZf = 1'b0;
        model(4'd6, 1'b0, 1'b1, 32'h00000002, 32'h00000003, mCf, eD, eZ, eC, eErr);
        runOp(4'd6, 1'b0, 1'b1, 32'h00000002, 32'h00000003, 1'b0, 0,
              d, z, c, err, lat, selBad, cinTr, protoBad);
        chk("post-reset rsp_data", 64'(d), 64'(eD));
        chk("post-reset latency", 64'(lat), 64'd2);
        chk("post-reset cf", 64'(cf), 64'(eC));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the 16-bit one-hot-select arithmetic unit.
- Accepts operation requests over a valid/ready handshake and drives the unit's operands, one-hot selects and carry-in.
- Captures the unit's result and flags, and returns them over a valid/ready response channel.
- Runs 32-bit "wide" logic/add/sub operations as two chained 16-bit passes. Holds the architectural carry and zero flags.

Parameters:
- NUM_OPS, 10, number of legal opcodes (0..NUM_OPS-1); fixed by the unit's select count.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  opcode: 0 pass-B, 1 and, 2 or, 3 not-B, 4 shl-B, 5 shr-B, 6 add, 7 sub, 8 mul8, 9 cmp; 10..15 illegal
- req_wide  in  1  32-bit operation
- req_usecf  in  1  add/sub carry-in taken from cf (else 0)
- req_a  in  32  operand A (low half only when narrow)
- req_b  in  32  operand B
- alu_a  out  16  operand A to unit
- alu_b  out  16  operand B to unit
- alu_sel  out  10  one-hot selects, bit9..bit0 = pass-B, and, or, not, shl, shr, add, sub, mul, cmp
- alu_cin  out  1  carry-in to unit
- alu_out  in  16  unit result
- alu_zout  in  1  unit zero/equal flag
- alu_cout  in  1  unit carry/greater flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  result; upper 16 bits are 0 when narrow
- rsp_z  out  1  zero flag of this operation
- rsp_c  out  1  carry flag of this operation
- rsp_err  out  1  request was illegal
- cf  out  1  architectural carry flag
- zf  out  1  architectural zero flag

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including req_ready, alu_sel, rsp_*, cf and zf. Any in-flight op is discarded with no response. req_ready rises in the first cycle after rst_n deasserts.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op, wide, usecf, a, b.
  - Illegal request (op>=10, or wide with op in {4,5,8,9}): go to RESP with rsp_err=1, rsp_data=0, rsp_z=0, rsp_c=0. No ALU pass is made.
  - Otherwise go to LO.
- LO:
  - alu_a=a[15:0], alu_b=b[15:0], alu_sel=one-hot(op).
  - alu_cin = (op in {6,7} & usecf) ? cf : 0.
  - At end of cycle, capture alu_out into res[15:0], alu_cout into c_lo, alu_zout into z_lo.
  - Go to HI if wide, else RESP.
- HI:
  - alu_a=a[31:16], alu_b=b[31:16], same select.
  - alu_cin = c_lo for op 6/7, else 0.
  - Capture res[31:16] and c_hi. rsp_z = z_lo & alu_zout. rsp_c = c_hi. Go to RESP.
- Narrow result: rsp_c=c_lo, rsp_z=z_lo, rsp_data={16'h0, res[15:0]}.
- alu_sel=0 and alu_cin=0 in IDLE and RESP. Exactly one select bit is high in LO/HI.
- RESP:
  - rsp_valid=1, with rsp_* stable until rsp_ready.
  - On rsp_valid&rsp_ready, return to IDLE. req_ready is 0 in that cycle, so there is no same-cycle re-accept.
- Flags: cf/zf load rsp_c/rsp_z on the cycle the FSM enters RESP for a legal op. Illegal ops leave the flags unchanged. cmp: cf=A>B, zf=A==B (narrow only).
- Latency (accept edge = cycle 0): narrow rsp_valid at cycle 2, wide at cycle 3, illegal at cycle 1.
- Throughput: one op outstanding. Back-pressure on rsp_ready stalls indefinitely with no state loss.

Test Plan:
- Narrow add: a=16'h0005, b=16'h0003, usecf=0 -> alu_sel=10'b0000001000 in LO; rsp_data=32'h00000008, rsp_c=0, rsp_z=0 at cycle 2; cf=0.
- Wide add with carry chain: a=32'h0000FFFF, b=32'h00000001 -> LO cin=0, HI cin=1; rsp_data=32'h00010000, rsp_c=0, rsp_z=0 at cycle 3.
- Carry-in from flag: set cf via narrow add FFFF+0001 (rsp_data=0, rsp_c=1, rsp_z=1). Then narrow add 0+0 with usecf=1 -> alu_cin=1, rsp_data=1, cf=0.
- Compare: a=16'h0007, b=16'h0007 op 9 -> rsp_z=1, rsp_c=0; a=9, b=2 -> rsp_c=1, rsp_z=0.
- Illegal: op=12 or wide shl -> rsp_err=1 at cycle 1, alu_sel never nonzero, cf/zf unchanged.
- Back-pressure and reset: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0. Then assert rst_n=0 mid-HI of a wide op -> all outputs 0 immediately, no response after release, next request served normally.
